// File: rtl/ppg_multi_ch_calib_ctrl_pkg.sv
// Shared types and helpers for the multi-channel PPG calibration controller.
// Holds the FSM state encoding plus width/midscale/one-hot helpers.
// Purely declarative; no logic of its own.
package ppg_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DC_WAIT   = 3'd1,
    S_DC_EVAL   = 3'd2,
    S_GAIN_WAIT = 3'd3,
    S_GAIN_EVAL = 3'd4,
    S_NEXT_CH   = 3'd5,
    S_RUN       = 3'd6
  } state_e;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Midscale code of a w-bit unsigned quantity.
  function automatic int mid_of(input int w);
    return 1 << (w - 1);
  endfunction

  // One-hot vector with bit idx set; callers slice it to their width.
  function automatic logic [31:0] onehot32(input int idx);
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/ppg_multi_ch_calib_ctrl_if.sv
// Front-end bundle between the calibration controller and ADC/LED/DAC/PGA.
// master = controller side, slave = analog front-end side.
// Plain wires; no timing of its own.
interface ppg_multi_ch_calib_ctrl_if #(
  parameter int ADC_W  = 8,
  parameter int DAC_W  = 7,
  parameter int GAIN_W = 4,
  parameter int N_CH   = 2
);
  localparam int CH_W = ppg_pkg::idx_w(N_CH);

  logic              find_setting;
  logic [ADC_W-1:0]  adc;
  logic [DAC_W-1:0]  dc_comp;
  logic [GAIN_W-1:0] pga_gain;
  logic [N_CH-1:0]   led_en;
  logic [CH_W-1:0]   ch_idx;
  logic              sample_valid;
  logic              busy;
  logic              cal_done;
  logic              cal_fail;

  modport master (
    input  find_setting, adc,
    output dc_comp, pga_gain, led_en, ch_idx, sample_valid, busy, cal_done, cal_fail
  );

  modport slave (
    output find_setting, adc,
    input  dc_comp, pga_gain, led_en, ch_idx, sample_valid, busy, cal_done, cal_fail
  );
endinterface

// File: rtl/ppg_multi_ch_calib_ctrl_sar_step.sv
// One successive-approximation step of the DC-compensation search.
// Combinational, zero latency.
// No flow control; evaluated only while the controller is in DC_EVAL.
module ppg_sar_step #(
  parameter int ADC_W = 8,
  parameter int DAC_W = 7,
  parameter int TOL   = 1,
  parameter int BIT_W = 3
) (
  input  logic [ADC_W-1:0] adc,
  input  logic [DAC_W-1:0] acc,
  input  logic [BIT_W-1:0] bitn,
  output logic             early_exit,
  output logic             last,
  output logic [DAC_W-1:0] acc_nxt,
  output logic [DAC_W-1:0] trial_nxt,
  output logic [ADC_W:0]   adc_dev
);
  import ppg_pkg::*;

  localparam logic [ADC_W-1:0] MID_V = ADC_W'(mid_of(ADC_W));
  localparam logic [ADC_W:0]   TOL_V = (ADC_W+1)'(TOL);
  localparam logic [DAC_W-1:0] ONE   = DAC_W'(1);

  logic signed [ADC_W:0] diff;
  logic                  above;

  // Signed distance from midscale, its magnitude, and the SAR bit decision.
  always_comb begin
    diff       = $signed({1'b0, adc}) - $signed({1'b0, MID_V});
    adc_dev    = diff[ADC_W] ? $unsigned(-diff) : $unsigned(diff);
    early_exit = (adc_dev <= TOL_V);
    above      = !diff[ADC_W] && (diff != '0);
    acc_nxt    = above ? (acc | (ONE << bitn)) : acc;
    last       = (bitn == '0);
    // Only meaningful when last is low, so bitn-1 never underflows in use.
    trial_nxt  = acc_nxt | (ONE << (bitn - 1'b1));
  end

endmodule

// File: rtl/ppg_multi_ch_calib_ctrl.sv
// Sequential DC-SAR + gain-ramp calibration of N_CH LED channels, then LED time-multiplexing.
// Outputs registered (one cycle after the deciding edge); sample_valid decoded from the slot counter.
// No backpressure: adc is sampled unconditionally after SETTLE_CYC cycles of settling.
module ppg_multi_ch_calib_ctrl #(
  parameter int ADC_W      = 8,
  parameter int DAC_W      = 7,
  parameter int GAIN_W     = 4,
  parameter int N_CH       = 2,
  parameter int SETTLE_CYC = 4,
  parameter int TOL        = 1,
  parameter int LIMIT      = 40,
  parameter int SLOT_CYC   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  ppg_multi_ch_calib_ctrl_if.master  bus
);
  import ppg_pkg::*;

  localparam int CH_W  = idx_w(N_CH);
  localparam int BIT_W = idx_w(DAC_W);
  localparam int CNT_W = idx_w((SLOT_CYC > SETTLE_CYC) ? SLOT_CYC : SETTLE_CYC);

  localparam logic [DAC_W-1:0]  DCMID      = DAC_W'(mid_of(DAC_W));
  localparam logic [GAIN_W-1:0] GMAX       = '1;
  localparam logic [ADC_W:0]    LIM_V      = (ADC_W+1)'(LIMIT);
  localparam logic [CH_W-1:0]   LAST_CH    = CH_W'(N_CH - 1);
  localparam logic [BIT_W-1:0]  TOP_BIT    = BIT_W'(DAC_W - 1);
  localparam logic [CNT_W-1:0]  SETTLE_END = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]  SLOT_END   = CNT_W'(SLOT_CYC - 1);

  function automatic logic [N_CH-1:0] oh(input logic [CH_W-1:0] i);
    logic [31:0] t;
    t = onehot32(int'(i));
    return t[N_CH-1:0];
  endfunction

  state_e            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DAC_W-1:0]  acc_q, acc_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DAC_W-1:0]  dc_comp_q, dc_comp_d;
  logic [GAIN_W-1:0] pga_gain_q, pga_gain_d;
  logic [N_CH-1:0]   led_en_q, led_en_d;
  logic              busy_q, busy_d;
  logic              cal_done_q, cal_done_d;
  logic              cal_fail_q, cal_fail_d;
  logic [DAC_W-1:0]  dc_mem_q [N_CH];
  logic [DAC_W-1:0]  dc_mem_d [N_CH];
  logic [GAIN_W-1:0] gain_mem_q [N_CH];
  logic [GAIN_W-1:0] gain_mem_d [N_CH];

  logic              early_exit, last;
  logic [DAC_W-1:0]  acc_nxt, trial_nxt;
  logic [ADC_W:0]    adc_dev;

  ppg_sar_step #(.ADC_W(ADC_W), .DAC_W(DAC_W), .TOL(TOL), .BIT_W(BIT_W)) u_sar (
    .adc        (bus.adc),
    .acc        (acc_q),
    .bitn       (bit_q),
    .early_exit (early_exit),
    .last       (last),
    .acc_nxt    (acc_nxt),
    .trial_nxt  (trial_nxt),
    .adc_dev    (adc_dev)
  );

  // Next-state and next-output decode for the calibration/run sequencer.
  always_comb begin
    logic [CH_W-1:0] nxt_ch;
    logic            restart;
    nxt_ch      = '0;
    state_d     = state_q;
    ch_d        = ch_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    bit_d       = bit_q;
    dc_comp_d   = dc_comp_q;
    pga_gain_d  = pga_gain_q;
    led_en_d    = led_en_q;
    busy_d      = busy_q;
    cal_done_d  = cal_done_q;
    cal_fail_d  = cal_fail_q;
    dc_mem_d    = dc_mem_q;
    gain_mem_d  = gain_mem_q;
    // Calibration can only be (re)started when not already calibrating.
    restart     = bus.find_setting && ((state_q == S_IDLE) || (state_q == S_RUN));

    case (state_q)
      S_IDLE: ;
      S_DC_WAIT: begin
        if (cnt_q == SETTLE_END) state_d = S_DC_EVAL;
        else                     cnt_d   = cnt_q + 1'b1;
      end
      S_DC_EVAL: begin
        if (early_exit || last) begin
          // Store the settled code and leave it on the DAC for the gain ramp.
          dc_mem_d[ch_q] = early_exit ? dc_comp_q : acc_nxt;
          dc_comp_d      = early_exit ? dc_comp_q : acc_nxt;
          pga_gain_d     = '0;
          cnt_d          = '0;
          state_d        = S_GAIN_WAIT;
        end else begin
          acc_d     = acc_nxt;
          bit_d     = bit_q - 1'b1;
          dc_comp_d = trial_nxt;
          cnt_d     = '0;
          state_d   = S_DC_WAIT;
        end
      end
      S_GAIN_WAIT: begin
        if (cnt_q == SETTLE_END) state_d = S_GAIN_EVAL;
        else                     cnt_d   = cnt_q + 1'b1;
      end
      S_GAIN_EVAL: begin
        if (adc_dev <= LIM_V) begin
          if (pga_gain_q == GMAX) begin
            gain_mem_d[ch_q] = GMAX;
            state_d          = S_NEXT_CH;
          end else begin
            pga_gain_d = pga_gain_q + 1'b1;
            cnt_d      = '0;
            state_d    = S_GAIN_WAIT;
          end
        end else begin
          // Back off to the last gain that stayed in range; none means failure.
          if (pga_gain_q == '0) begin
            gain_mem_d[ch_q] = '0;
            cal_fail_d       = 1'b1;
          end else begin
            gain_mem_d[ch_q] = pga_gain_q - 1'b1;
          end
          state_d = S_NEXT_CH;
        end
      end
      S_NEXT_CH: begin
        if (ch_q == LAST_CH) begin
          ch_d       = '0;
          cnt_d      = '0;
          busy_d     = 1'b0;
          cal_done_d = 1'b1;
          led_en_d   = oh('0);
          dc_comp_d  = dc_mem_d[0];
          pga_gain_d = gain_mem_d[0];
          state_d    = S_RUN;
        end else begin
          // Gain is parked at 0 so each channel's DC search sees the same PGA setting.
          ch_d       = ch_q + 1'b1;
          led_en_d   = oh(ch_q + 1'b1);
          dc_comp_d  = DCMID;
          pga_gain_d = '0;
          acc_d      = '0;
          bit_d      = TOP_BIT;
          cnt_d      = '0;
          state_d    = S_DC_WAIT;
        end
      end
      S_RUN: begin
        if (cnt_q == SLOT_END) begin
          nxt_ch     = (ch_q == LAST_CH) ? '0 : ch_q + 1'b1;
          cnt_d      = '0;
          ch_d       = nxt_ch;
          led_en_d   = oh(nxt_ch);
          dc_comp_d  = dc_mem_q[nxt_ch];
          pga_gain_d = gain_mem_q[nxt_ch];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = S_IDLE;
        ch_d       = '0;
        cnt_d      = '0;
        acc_d      = '0;
        bit_d      = TOP_BIT;
        dc_comp_d  = DCMID;
        pga_gain_d = '0;
        led_en_d   = '0;
        busy_d     = 1'b0;
        cal_done_d = 1'b0;
        cal_fail_d = 1'b0;
      end
    endcase

    if (restart) begin
      state_d    = S_DC_WAIT;
      ch_d       = '0;
      cnt_d      = '0;
      busy_d     = 1'b1;
      cal_done_d = 1'b0;
      cal_fail_d = 1'b0;
      led_en_d   = oh('0);
      pga_gain_d = '0;
      acc_d      = '0;
      bit_d      = TOP_BIT;
      dc_comp_d  = DCMID;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ch_q       <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      bit_q      <= TOP_BIT;
      dc_comp_q  <= DCMID;
      pga_gain_q <= '0;
      led_en_q   <= '0;
      busy_q     <= 1'b0;
      cal_done_q <= 1'b0;
      cal_fail_q <= 1'b0;
      dc_mem_q   <= '{default: '0};
      gain_mem_q <= '{default: '0};
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      bit_q      <= bit_d;
      dc_comp_q  <= dc_comp_d;
      pga_gain_q <= pga_gain_d;
      led_en_q   <= led_en_d;
      busy_q     <= busy_d;
      cal_done_q <= cal_done_d;
      cal_fail_q <= cal_fail_d;
      dc_mem_q   <= dc_mem_d;
      gain_mem_q <= gain_mem_d;
    end
  end

  assign bus.dc_comp      = dc_comp_q;
  assign bus.pga_gain     = pga_gain_q;
  assign bus.led_en       = led_en_q;
  assign bus.ch_idx       = ch_q;
  assign bus.busy         = busy_q;
  assign bus.cal_done     = cal_done_q;
  assign bus.cal_fail     = cal_fail_q;
  assign bus.sample_valid = (state_q == S_RUN) && (cnt_q == SLOT_END);

endmodule
